bscan_byte_link: RTL and testbench
==================================

// Module: bscan_byte_link
// PURPOSE
//  Front-end of user_logic: sole consumer of the BSCAN USER-chain signals. Deserializes 8-bit DR
//  scans (LSB first) into a byte stream for the puzzle solver, buffered in a small FIFO. Flags end of
//  input (two consecutive 0x0A bytes). Serializes the solver's result onto tdo during read-back scans.
// PARAMETERS
//  RESULT_WIDTH  16  width of result register / read-back DR scan
//  FIFO_DEPTH    4   byte FIFO entries (power of two, >=2)
// PORTS
//  tck               in   1             JTAG clock, all logic on posedge
//  rst_n             in   1             synchronous active-low reset
//  tdi               in   1             serial data in
//  tdo               out  1             serial data out (registered bit 0 of out-shift reg)
//  test_logic_reset  in   1             TAP in Test-Logic-Reset
//  run_test_idle     in   1             TAP in Run-Test/Idle (unused except as idle marker)
//  ir_is_user        in   1             IR selects this USER chain; qualifies capture/shift/update
//  capture_dr        in   1             TAP in Capture-DR
//  shift_dr          in   1             TAP in Shift-DR
//  update_dr         in   1             TAP in Update-DR
//  byte_valid        out  1             FIFO head valid
//  byte_data         out  8             FIFO head byte
//  byte_ready        in   1             consumer accepts head when byte_valid & byte_ready
//  end_of_input      out  1             one-cycle pulse: second of two consecutive 0x0A bytes accepted
//  overflow          out  1             sticky: byte dropped because FIFO full
//  result            in   RESULT_WIDTH  solver result
//  result_valid      in   1             result is final
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): tdo=0, byte_valid=0, byte_data=0, end_of_input=0, overflow=0;
//    FIFO empty, shift regs and bit counter 0, prev_was_lf=0.
//  - All TAP strobes ignored unless ir_is_user=1.
//  - capture_dr: bit_cnt<=0; out_sr<=result_valid ? result : 0; in_sr unchanged.
//  - shift_dr: in_sr<={tdi,in_sr[7:1]}; out_sr<={1'b0,out_sr[RESULT_WIDTH-1:1]};
//    bit_cnt saturates at 2^5-1 (5-bit). tdo=out_sr[0] registered path, so after capture bit 0 of
//    result is on tdo before the first shift edge; bit k visible after k shift edges.
//  - update_dr: if bit_cnt==8 -> push in_sr into FIFO; any other count (e.g. 16-bit read-back,
//    aborted scan) -> no push. Push when full: byte dropped, overflow<=1 (cleared only by rst_n).
//  - Push latency: byte_valid high the cycle after update_dr posedge (FIFO write registered).
//  - FIFO: standard circular buffer, ptrs wrap at FIFO_DEPTH, extra count bit for full/empty.
//    Simultaneous push and pop when full: pop frees slot, push accepted, no overflow.
//    Simultaneous push/pop when empty: push only (no fall-through).
//  - End detect on accepted push: if byte==0x0A and prev_was_lf -> end_of_input=1 next cycle,
//    prev_was_lf<=0; else prev_was_lf<=(byte==0x0A). Dropped bytes do not affect prev_was_lf.
//  - test_logic_reset=1: bit_cnt<=0, in_sr<=0, out_sr<=0; FIFO, overflow, prev_was_lf kept
//    (a TAP reset mid-scan aborts that byte only).
//  - capture/shift/update are mutually exclusive by TAP construction; no priority required.
// TESTING
//  - Scan 0x41 LSB-first (8 shifts) + update -> byte_valid=1 next cycle, byte_data=0x41; pop clears.
//  - Scan 7 bits then update -> no push; scan 9 bits -> no push; 16-bit read-back scan -> no push.
//  - byte_ready=0, push 5 bytes with FIFO_DEPTH=4 -> 4 stored in order, overflow=1, 5th lost.
//  - Push "a",0x0A,"b",0x0A,0x0A -> single end_of_input pulse after last byte only.
//  - result=16'h1234,result_valid=1; capture+16 shifts sampling tdo before each edge -> 0x1234;
//    result_valid=0 -> reads 0x0000.
//  - test_logic_reset asserted after 4 shift bits, then full 8-bit scan of 0x5A -> only 0x5A pushed.

Source files
------------

// File: rtl/bscan_byte_link.sv
// JTAG USER-chain front end: deserializes 8-bit DR scans into a byte FIFO,
// flags end of input (two consecutive LF bytes) and shifts the result out on tdo.
module bscan_byte_link #(
  parameter int RESULT_WIDTH = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    tck,
  input  logic                    rst_n,
  input  logic                    tdi,
  output logic                    tdo,
  input  logic                    test_logic_reset,
  input  logic                    run_test_idle,
  input  logic                    ir_is_user,
  input  logic                    capture_dr,
  input  logic                    shift_dr,
  input  logic                    update_dr,
  output logic                    byte_valid,
  output logic [7:0]              byte_data,
  input  logic                    byte_ready,
  output logic                    end_of_input,
  output logic                    overflow,
  input  logic [RESULT_WIDTH-1:0] result,
  input  logic                    result_valid
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [7:0] LF = 8'h0A;

  logic [7:0]              in_sr;
  logic [RESULT_WIDTH-1:0] out_sr;
  logic [4:0]              bit_cnt;
  logic [7:0]              mem [FIFO_DEPTH];
  logic [AW:0]             wr_ptr;
  logic [AW:0]             rd_ptr;
  logic                    prev_was_lf;
  logic                    eoi_q;
  logic                    ovf_q;

  logic fifo_empty;
  logic fifo_full;
  logic push_req;
  logic pop;
  logic push_ok;

  // Idle state carries no information for this chain.
  logic unused_idle;
  assign unused_idle = run_test_idle;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Only a scan of exactly 8 bits delivers a byte; read-backs and aborted scans are ignored.
  assign push_req = ir_is_user && update_dr && !test_logic_reset && (bit_cnt == 5'd8);
  assign pop      = !fifo_empty && byte_ready;
  assign push_ok  = push_req && (!fifo_full || pop);

  assign byte_valid   = !fifo_empty;
  assign byte_data    = fifo_empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
  assign tdo          = out_sr[0];
  assign end_of_input = eoi_q;
  assign overflow     = ovf_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge tck) begin
    if (!rst_n) begin
      in_sr       <= '0;
      out_sr      <= '0;
      bit_cnt     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      prev_was_lf <= 1'b0;
      eoi_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      eoi_q <= 1'b0;

      // A TAP reset aborts the scan in flight but leaves queued bytes alone.
      if (test_logic_reset) begin
        bit_cnt <= '0;
        in_sr   <= '0;
        out_sr  <= '0;
      end else if (ir_is_user) begin
        if (capture_dr) begin
          bit_cnt <= '0;
          out_sr  <= result_valid ? result : '0;
        end
        if (shift_dr) begin
          in_sr  <= {tdi, in_sr[7:1]};
          out_sr <= {1'b0, out_sr[RESULT_WIDTH-1:1]};
          if (bit_cnt != 5'h1F) bit_cnt <= bit_cnt + 5'd1;
        end
      end

      if (pop) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};

      if (push_ok) begin
        wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
        if (in_sr == LF && prev_was_lf) begin
          eoi_q       <= 1'b1;
          prev_was_lf <= 1'b0;
        end else begin
          prev_was_lf <= (in_sr == LF);
        end
      end else if (push_req) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // NOTE: FIFO storage is not reset; the pointers alone define which entries
  // are live, and byte_data is forced to zero while the FIFO is empty.
  always_ff @(posedge tck) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= in_sr;
  end

endmodule

// File: tb/tb_bscan_byte_link.sv
// Randomized bench for bscan_byte_link: a queue-based model of scans, FIFO and
// read-back is compared with the DUT on every falling edge, plus literal checks.
module tb_bscan_byte_link;

  localparam int DEPTH = 4;
  localparam int RW    = 16;

  logic          tck = 1'b0;
  logic          rst_n;
  logic          tdi;
  logic          tdo;
  logic          test_logic_reset;
  logic          run_test_idle;
  logic          ir_is_user;
  logic          capture_dr;
  logic          shift_dr;
  logic          update_dr;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          end_of_input;
  logic          overflow;
  logic [RW-1:0] result;
  logic          result_valid;

  bscan_byte_link #(.RESULT_WIDTH(RW), .FIFO_DEPTH(DEPTH)) dut (
    .tck              (tck),
    .rst_n            (rst_n),
    .tdi              (tdi),
    .tdo              (tdo),
    .test_logic_reset (test_logic_reset),
    .run_test_idle    (run_test_idle),
    .ir_is_user       (ir_is_user),
    .capture_dr       (capture_dr),
    .shift_dr         (shift_dr),
    .update_dr        (update_dr),
    .byte_valid       (byte_valid),
    .byte_data        (byte_data),
    .byte_ready       (byte_ready),
    .end_of_input     (end_of_input),
    .overflow         (overflow),
    .result           (result),
    .result_valid     (result_valid)
  );

  always #5 tck = ~tck;

  int n_cmp = 0;
  int n_bad = 0;
  int eoi_seen = 0;
  bit rand_ready = 1'b0;
  logic last_tdo;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         m_live = 1'b0;
  logic [7:0] m_q[$];
  bit         m_bits[$];
  logic [RW-1:0] m_rd_word;
  int         m_rd_idx;
  bit         m_ovf, m_eoi, m_prev_lf;
  bit         do_pop, do_push;
  logic [7:0] pb;

  always @(posedge tck) begin
    if (!rst_n) begin
      m_q.delete(); m_bits.delete();
      m_rd_word = '0; m_rd_idx = 0;
      m_ovf = 0; m_eoi = 0; m_prev_lf = 0;
      m_live = 1'b1;
    end else if (m_live) begin
      do_pop  = (m_q.size() > 0) && byte_ready;
      do_push = 1'b0;
      pb      = 8'h00;
      m_eoi   = 1'b0;
      if (test_logic_reset) begin
        m_bits.delete();
        m_rd_word = '0; m_rd_idx = 0;
      end else if (ir_is_user) begin
        if (capture_dr) begin
          m_bits.delete();
          m_rd_word = result_valid ? result : '0;
          m_rd_idx  = 0;
        end
        if (shift_dr) begin
          m_bits.push_back(tdi);
          m_rd_idx++;
        end
        if (update_dr && m_bits.size() == 8) begin
          do_push = 1'b1;
          foreach (m_bits[i]) pb[i] = m_bits[i];
        end
      end
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
        if (m_q.size() < DEPTH) begin
          m_q.push_back(pb);
          if (pb == 8'h0A && m_prev_lf) begin
            m_eoi = 1'b1; m_prev_lf = 1'b0;
          end else begin
            m_prev_lf = (pb == 8'h0A);
          end
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge tck) begin
    if (m_live) begin
      check("byte_valid", byte_valid, m_q.size() > 0);
      if (m_q.size() > 0) check("byte_data", byte_data, m_q[0]);
      check("end_of_input", end_of_input, m_eoi);
      check("overflow", overflow, m_ovf);
      check("tdo", tdo, (m_rd_idx < RW) ? m_rd_word[m_rd_idx] : 1'b0);
      if (end_of_input === 1'b1) eoi_seen++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic c, input logic s, input logic u, input logic t, input logic d);
    @(negedge tck);
    last_tdo         = tdo;
    capture_dr       = c;
    shift_dr         = s;
    update_dr        = u;
    test_logic_reset = t;
    tdi              = d;
    run_test_idle    = !(c | s | u | t);
    if (rand_ready) byte_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic scan(input logic [7:0] b, input int nbits, input bit cap);
    if (cap) step(1, 0, 0, 0, 0);
    for (int i = 0; i < nbits; i++)
      step(0, 1, 0, 0, (i < 8) ? b[i] : 1'($urandom_range(0, 1)));
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
  endtask

  task automatic readback(output logic [RW-1:0] w);
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < RW; k++) begin
      step(0, 1, 0, 0, 0);
      w[k] = last_tdo;
    end
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    byte_ready = 1'b1;
    for (int i = 0; i <= DEPTH; i++) step(0, 0, 0, 0, 0);
    byte_ready = 1'b0;
    step(0, 0, 0, 0, 0);
  endtask

  task automatic pop_one();
    byte_ready = 1'b1;
    step(0, 0, 0, 0, 0);
    byte_ready = 1'b0;
  endtask

  logic [RW-1:0] word;
  int            eoi_before;
  int            op;

  initial begin
    rst_n = 1'b0; tdi = 0; test_logic_reset = 0; run_test_idle = 1; ir_is_user = 1;
    capture_dr = 0; shift_dr = 0; update_dr = 0; byte_ready = 0;
    result = '0; result_valid = 0;
    repeat (3) step(0, 0, 0, 0, 0);
    rst_n = 1'b1;
    check("reset tdo", tdo, 1'b0);
    check("reset byte_valid", byte_valid, 1'b0);
    check("reset byte_data", byte_data, 8'h00);
    check("reset end_of_input", end_of_input, 1'b0);
    check("reset overflow", overflow, 1'b0);

    // Single byte 0x41.
    scan(8'h41, 8, 1);
    check("0x41 valid", byte_valid, 1'b1);
    check("0x41 data", byte_data, 8'h41);
    pop_one();
    check("0x41 popped", byte_valid, 1'b0);

    // Wrong-length scans push nothing.
    scan(8'h77, 7, 1);
    scan(8'h77, 9, 1);
    result = 16'hBEEF; result_valid = 1;
    readback(word);
    check("bad lengths no push", byte_valid, 1'b0);

    // Read-back of result.
    result = 16'h1234; result_valid = 1;
    readback(word);
    check("readback 1234", word, 16'h1234);
    result_valid = 0;
    readback(word);
    check("readback invalid", word, 16'h0000);

    // TAP reset after 4 shift bits, then a full 8-bit scan without capture.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 1'b1);
    step(0, 0, 0, 1, 0);
    scan(8'h5A, 8, 0);
    check("tlr data", byte_data, 8'h5A);
    pop_one();
    check("tlr single push", byte_valid, 1'b0);

    // End-of-input detection.
    byte_ready = 1'b1;
    eoi_before = eoi_seen;
    scan(8'h61, 8, 1); scan(8'h0A, 8, 1); scan(8'h62, 8, 1); scan(8'h0A, 8, 1);
    check("no early eoi", eoi_seen - eoi_before, 0);
    scan(8'h0A, 8, 1);
    step(0, 0, 0, 0, 0);
    check("one eoi pulse", eoi_seen - eoi_before, 1);
    drain();

    // Overflow: five pushes into a four-entry FIFO.
    check("pre-overflow", overflow, 1'b0);
    for (int k = 1; k <= 5; k++) scan(8'(k * 8'h11), 8, 1);
    check("overflow set", overflow, 1'b1);
    check("ovf head 0x11", byte_data, 8'h11);
    pop_one();
    check("ovf head 0x22", byte_data, 8'h22);
    pop_one();
    check("ovf head 0x33", byte_data, 8'h33);
    pop_one();
    check("ovf head 0x44", byte_data, 8'h44);
    pop_one();
    check("5th lost", byte_valid, 1'b0);
    rst_n = 1'b0;
    step(0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0);
    check("overflow cleared by reset", overflow, 1'b0);

    // Randomized phase against the model.
    rand_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      op           = $urandom_range(0, 9);
      ir_is_user   = ($urandom_range(0, 9) != 0);
      result       = 16'($urandom);
      result_valid = 1'($urandom_range(0, 1));
      if (op <= 5) begin
        scan(($urandom_range(0, 1) != 0) ? 8'h0A : 8'($urandom),
             (op == 4) ? 7 : (op == 5) ? 9 : 8, 1);
      end else if (op == 6) begin
        readback(word);
      end else if (op == 7) begin
        step(1, 0, 0, 0, 0);
        for (int i = 0, lim = $urandom_range(0, 7); i < lim; i++)
          step(0, 1, 0, 0, 1'($urandom_range(0, 1)));
        step(0, 0, 0, 1, 0);
        scan(8'($urandom), 8, 0);
      end else begin
        repeat ($urandom_range(1, 4)) step(0, 0, 0, 0, 0);
      end
    end
    rand_ready = 1'b0;
    ir_is_user = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
